// File: rtl/led_seq_ctrl.sv
// LED step sequencer: debounced buttons drive an OFF/RUN/PAUSE FSM stepping an 8-entry LED pattern.
// Latency: press event ~2^DB_BITS+2 cycles after a raw press; LEDs/STEP 1 cycle after the index moves.
// Backpressure: none; button events are consumed the cycle they occur and outputs are free-running.
module led_seq_ctrl #(
  parameter int DB_BITS   = 16,
  parameter int LOG2DELAY = 22
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_N,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic [1:0] MODE,
  output logic       STEP
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  // All buttons normalised to active-high "pressed": bit0 run/pause, bit1 up, bit2 down, bit3 step/reverse
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] press;

  assign raw = {BTN3, BTN2, BTN1, ~BTN_N};

  // Two-flop synchroniser; left unreset so a button held through reset is seen as held immediately
  always_ff @(posedge CLK) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_db
    logic [DB_BITS-1:0] cnt;
    logic               stab;
    logic               arm;
    logic               evt;

    // Debounce: count while input differs from the stable value, accept at saturation.
    // arm is only set once the button has been seen released, so a press held over reset is ignored.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        cnt  <= '0;
        stab <= 1'b0;
        arm  <= 1'b0;
        evt  <= 1'b0;
      end else begin
        evt <= 1'b0;
        if (!sync2[g]) arm <= 1'b1;
        if (sync2[g] == stab) begin
          cnt <= '0;
        end else if (&cnt) begin
          stab <= sync2[g];
          cnt  <= '0;
          evt  <= sync2[g] & arm;
        end else begin
          cnt <= cnt + DB_BITS'(1);
        end
      end
    end

    assign press[g] = evt;
  end

  function automatic logic [4:0] pat_of(input logic [2:0] i);
    case (i)
      3'd0:    pat_of = 5'b00001;
      3'd1:    pat_of = 5'b01000;
      3'd2:    pat_of = 5'b00010;
      3'd3:    pat_of = 5'b00100;
      3'd4:    pat_of = 5'b10001;
      3'd5:    pat_of = 5'b11000;
      3'd6:    pat_of = 5'b10010;
      default: pat_of = 5'b10100;
    endcase
  endfunction

  state_t               state;
  logic [1:0]           speed;
  logic [2:0]           idx;
  logic                 dir;
  logic [LOG2DELAY-1:0] presc;
  logic                 step_d;
  logic [4:0]           led_q;

  logic                 spd_inc;
  logic                 spd_dec;
  logic                 speed_chg;
  logic [LOG2DELAY-1:0] presc_tc;
  logic                 tick;
  logic                 btn3_ok;
  logic                 do_step;

  // Simultaneous up/down cancel; a run/pause event in the same cycle swallows step/reverse
  assign spd_inc   = press[1] & ~press[2];
  assign spd_dec   = press[2] & ~press[1];
  assign speed_chg = (spd_inc && speed != 2'd3) || (spd_dec && speed != 2'd0);
  assign presc_tc  = {LOG2DELAY{1'b1}} >> speed;
  assign tick      = (state == S_RUN) && (presc == presc_tc);
  assign btn3_ok   = press[3] & ~press[0];
  assign do_step   = tick || ((state == S_PAUSE) && btn3_ok);

  // FSM, speed, prescaler, index and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= S_OFF;
      speed  <= 2'd0;
      idx    <= 3'd0;
      dir    <= 1'b0;
      presc  <= '0;
      step_d <= 1'b0;
      led_q  <= 5'b00000;
      MODE   <= 2'b00;
      STEP   <= 1'b0;
    end else begin
      case (state)
        S_OFF:   if (press[0]) state <= S_RUN;
        S_RUN:   if (press[0]) state <= S_PAUSE;
        S_PAUSE: if (press[0]) state <= S_RUN;
        default: state <= S_OFF;
      endcase

      if (spd_inc && speed != 2'd3)      speed <= speed + 2'd1;
      else if (spd_dec && speed != 2'd0) speed <= speed - 2'd1;

      // A speed change restarts the period; otherwise count only while running
      if (speed_chg)            presc <= '0;
      else if (state == S_RUN)  presc <= tick ? '0 : presc + LOG2DELAY'(1);

      if ((state == S_RUN) && btn3_ok) dir <= ~dir;
      if (do_step) idx <= dir ? idx - 3'd1 : idx + 3'd1;

      step_d <= do_step;
      STEP   <= step_d;
      led_q  <= (state == S_OFF) ? 5'b00000 : pat_of(idx);
      MODE   <= state;
    end
  end

  assign {LED1, LED2, LED3, LED4, LED5} = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with DB_BITS=2, LOG2DELAY=4.
// Stimulus pushes expected MODE changes and STEP events; a negedge monitor pops and compares.
module tb_led_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_N = 1'b1;
  logic       BTN1 = 1'b0;
  logic       BTN2 = 1'b0;
  logic       BTN3 = 1'b0;
  logic       LED1, LED2, LED3, LED4, LED5;
  logic [1:0] MODE;
  logic       STEP;

  led_seq_ctrl #(.DB_BITS(2), .LOG2DELAY(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_N(BTN_N), .BTN1(BTN1), .BTN2(BTN2), .BTN3(BTN3),
    .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5),
    .MODE(MODE), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] mode;
    logic [4:0] leds;
  } mode_exp_t;

  typedef struct packed {
    logic [4:0] leds;
    int         gap;   // cycles since previous observed event; 0 = not checked
  } step_exp_t;

  mode_exp_t mode_q[$];
  step_exp_t step_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_obs = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_mode = 2'b00;
  logic [4:0] prev_leds = 5'b00000;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every MODE change and every STEP pulse is an output event to score
  always @(negedge CLK) begin : mon
    logic [4:0] leds_now;
    mode_exp_t  me;
    step_exp_t  se;
    bit         evt;
    if (mon_en) begin
      leds_now = {LED1, LED2, LED3, LED4, LED5};
      evt = 1'b0;
      if (MODE != prev_mode) begin
        evt = 1'b1;
        total++;
        if (mode_q.size() == 0) begin
          bad++;
          $display("FAIL mode_unexpected got mode=%b leds=%b at cyc %0d", MODE, leds_now, cyc);
        end else begin
          me = mode_q.pop_front();
          if (MODE !== me.mode || leds_now !== me.leds) begin
            bad++;
            $display("FAIL mode_change got mode=%b leds=%b want mode=%b leds=%b", MODE, leds_now, me.mode, me.leds);
          end
        end
        last_obs = cyc;
      end
      if (STEP) begin
        evt = 1'b1;
        total++;
        if (step_q.size() == 0) begin
          bad++;
          $display("FAIL step_unexpected got leds=%b at cyc %0d", leds_now, cyc);
        end else begin
          se = step_q.pop_front();
          if (leds_now !== se.leds || (se.gap != 0 && (cyc - last_obs) != se.gap)) begin
            bad++;
            $display("FAIL step got leds=%b gap=%0d want leds=%b gap=%0d", leds_now, cyc - last_obs, se.leds, se.gap);
          end
        end
        last_obs = cyc;
      end
      if (!evt) begin
        total++;
        if (leds_now !== prev_leds) begin
          bad++;
          $display("FAIL led_stray got leds=%b want leds=%b (no STEP/MODE change)", leds_now, prev_leds);
        end
      end
      prev_mode = MODE;
      prev_leds = leds_now;
    end
  end

  task automatic push_mode(input logic [1:0] m, input logic [4:0] l);
    mode_exp_t e;
    e.mode = m;
    e.leds = l;
    mode_q.push_back(e);
  endtask

  task automatic push_step(input logic [4:0] l, input int gap);
    step_exp_t e;
    e.leds = l;
    e.gap  = gap;
    step_q.push_back(e);
  endtask

  // Press a set of buttons together for 'hold' cycles, then release and idle 'rel' cycles
  task automatic press(input bit n, input bit b1, input bit b2, input bit b3, input int hold, input int rel);
    @(posedge CLK); #1;
    if (n)  BTN_N = 1'b0;
    if (b1) BTN1 = 1'b1;
    if (b2) BTN2 = 1'b1;
    if (b3) BTN3 = 1'b1;
    repeat (hold) @(posedge CLK);
    #1;
    BTN_N = 1'b1;
    BTN1  = 1'b0;
    BTN2  = 1'b0;
    BTN3  = 1'b0;
    repeat (rel) @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) until every pushed expectation has been matched by the monitor
  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((mode_q.size() != 0 || step_q.size() != 0) && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    total++;
    if (mode_q.size() != 0 || step_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s pending mode=%0d step=%0d want 0 0", tag, mode_q.size(), step_q.size());
      mode_q.delete();
      step_q.delete();
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial begin
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_mode", {6'd0, MODE}, 8'd0);
    check("rst_leds", {3'd0, LED1, LED2, LED3, LED4, LED5}, 8'd0);
    check("rst_step", {7'd0, STEP}, 8'd0);
    mon_en = 1'b1;

    // OFF -> RUN, first step 16 cycles after MODE goes to RUN
    push_mode(2'b01, 5'b00001);
    push_step(5'b01000, 16);
    press(1, 0, 0, 0, 8, 10);
    wait_drain(100, "start");

    // RUN -> PAUSE just after a step, then a single manual step
    push_mode(2'b10, 5'b01000);
    press(1, 0, 0, 0, 8, 10);
    wait_drain(60, "pause");
    push_step(5'b00010, 0);
    press(0, 0, 0, 1, 8, 10);
    wait_drain(60, "pause_step");

    // BTN_N and BTN3 together in PAUSE: resume only, BTN3 dropped
    push_mode(2'b01, 5'b00010);
    push_step(5'b00100, 0);
    press(1, 0, 0, 1, 8, 2);
    wait_drain(100, "resume_combo");

    // Reverse in RUN: 3 -> 2 -> 1 -> 0 -> 7
    push_step(5'b00010, 16);
    push_step(5'b01000, 16);
    push_step(5'b00001, 16);
    push_step(5'b10100, 16);
    press(0, 0, 0, 1, 8, 2);
    wait_drain(200, "reverse");

    // Forward again: 7 -> 0
    push_step(5'b00001, 16);
    press(0, 0, 0, 1, 8, 2);
    wait_drain(100, "forward");

    // Pause; speed up x4 (saturate at 3), down once, up+down together -> speed 2
    push_mode(2'b10, 5'b00001);
    press(1, 0, 0, 0, 8, 10);
    wait_drain(60, "pause2");
    repeat (4) press(0, 1, 0, 0, 8, 10);
    press(0, 0, 1, 0, 8, 10);
    press(0, 1, 1, 0, 8, 10);

    // Resume at speed 2: steps every 4 cycles up to index 5
    push_mode(2'b01, 5'b00001);
    push_step(5'b01000, 0);
    push_step(5'b00010, 4);
    push_step(5'b00100, 4);
    push_step(5'b10001, 4);
    push_step(5'b11000, 4);
    press(1, 0, 0, 0, 8, 2);
    wait_drain(200, "speed2");

    // Reset at index 5 with BTN_N held through reset release: no event afterwards
    push_mode(2'b00, 5'b00000);
    RST_N = 1'b0;
    BTN_N = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (12) @(posedge CLK);
    #1 BTN_N = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    wait_drain(20, "reset_held");

    // Fresh press after release: index 0, speed 0
    push_mode(2'b01, 5'b00001);
    push_step(5'b01000, 16);
    press(1, 0, 0, 0, 8, 10);
    wait_drain(100, "after_reset");

    // 3-cycle glitches on BTN_N and BTN3 must not pause or reverse
    push_step(5'b00010, 16);
    press(1, 0, 0, 0, 3, 2);
    press(0, 0, 0, 1, 3, 2);
    wait_drain(60, "glitch");

    // Pause, speed up x4 to 3, resume: steps every 2 cycles with 7 -> 0 wrap
    push_mode(2'b10, 5'b00010);
    press(1, 0, 0, 0, 8, 10);
    wait_drain(60, "pause3");
    repeat (4) press(0, 1, 0, 0, 8, 10);
    push_mode(2'b01, 5'b00010);
    push_step(5'b00100, 0);
    push_step(5'b10001, 2);
    push_step(5'b11000, 2);
    push_step(5'b10010, 2);
    push_step(5'b10100, 2);
    push_step(5'b00001, 2);
    push_step(5'b01000, 2);
    push_step(5'b00010, 2);
    push_step(5'b00100, 2);
    push_step(5'b10001, 2);
    push_step(5'b11000, 2);
    press(1, 0, 0, 0, 8, 2);
    wait_drain(200, "speed3");

    // Reset mid-run at index 5
    push_mode(2'b00, 5'b00000);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    wait_drain(20, "reset_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
